// File: rtl/writeback_regfile_pkg.sv
// Shared definitions for the writeback stage and the execute forwarding unit.
package writeback_regfile_pkg;

    localparam int REG_NUM   = 32;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = $clog2(REG_NUM);
    localparam int NUM_LANES = 2;   // lane 0 = upper, lane 1 = lower (later in program order)
    localparam int NUM_RD    = 4;   // u_rs, u_rt_src, l_rs, l_rt_src
    localparam int LANE_U    = 0;
    localparam int LANE_L    = 1;

    // One lane's commit as seen by the register file and the forwarding network.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_lane_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Memory-stage bundle in, register reads / forwarding / retire status out.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int RETIRE_W = 48
);
    logic                               interlock;
    logic                               valid;
    logic [31:0]                        pc;
    logic [ADDR_W-1:0]                  u_rt;
    logic [ADDR_W-1:0]                  l_rt;
    logic                               u_rt_flag;
    logic                               l_rt_flag;
    logic                               u_is_load;
    logic                               l_is_load;
    logic [DATA_W-1:0]                  u_alu;
    logic [DATA_W-1:0]                  l_alu;
    logic [DATA_W-1:0]                  mem_douta;
    logic [DATA_W-1:0]                  mem_doutb;
    logic [NUM_RD-1:0][ADDR_W-1:0]      rs_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]      rs_data;
    logic                               fwd_u_we;
    logic [ADDR_W-1:0]                  fwd_u_rd;
    logic [DATA_W-1:0]                  fwd_u_data;
    logic                               fwd_l_we;
    logic [ADDR_W-1:0]                  fwd_l_rd;
    logic [DATA_W-1:0]                  fwd_l_data;
    logic [31:0]                        last_pc;
    logic [RETIRE_W-1:0]                retired;

    // Memory stage / decode / execute side
    modport master (
        output interlock, valid, pc, u_rt, l_rt, u_rt_flag, l_rt_flag,
               u_is_load, l_is_load, u_alu, l_alu, mem_douta, mem_doutb, rs_addr,
        input  rs_data, fwd_u_we, fwd_u_rd, fwd_u_data,
               fwd_l_we, fwd_l_rd, fwd_l_data, last_pc, retired
    );

    // Writeback stage side
    modport slave (
        input  interlock, valid, pc, u_rt, l_rt, u_rt_flag, l_rt_flag,
               u_is_load, l_is_load, u_alu, l_alu, mem_douta, mem_doutb, rs_addr,
        output rs_data, fwd_u_we, fwd_u_rd, fwd_u_data,
               fwd_l_we, fwd_l_rd, fwd_l_data, last_pc, retired
    );

endinterface

// File: rtl/writeback_regfile_rf2w4r.sv
// 32x32 integer register file: 2 write ports, 4 combinational read ports with
// same-cycle write bypass. r0 is never written and always reads as zero.
module regfile_2w4r
    import writeback_regfile_pkg::*;
#(
    parameter int NUM_WR  = NUM_LANES,
    parameter int NUM_RDP = NUM_RD
)(
    input  logic                           clk,
    input  logic                           rstn,
    input  wb_lane_t [NUM_WR-1:0]          wr,
    input  logic [NUM_RDP-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_RDP-1:0][DATA_W-1:0] rd_data
);

    logic [REG_NUM-1:0][DATA_W-1:0] mem_q;

    // Array write; higher-index ports are later in program order so they are applied last and win
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr[w].we && (wr[w].rd != '0))
                    mem_q[wr[w].rd] <= wr[w].data;
            end
        end
    end

    // Reads: array value, overridden by this cycle's commits (latest port wins), r0 forced to zero
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RDP; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr[w].we && (wr[w].rd == rd_addr[p]))
                    rd_data[p] = wr[w].data;
            end
            if (rd_addr[p] == '0)
                rd_data[p] = '0;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage of the dual-issue core: per-lane result select, commit
// qualification, register file, forwarding outputs and retire counters.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int RETIRE_W = 48
)(
    input  logic                clk,
    input  logic                rstn,
    writeback_regfile_if.slave  bus
);

    logic                                commit;
    logic [NUM_LANES-1:0][ADDR_W-1:0]    lane_rt;
    logic [NUM_LANES-1:0]                lane_flag;
    logic [NUM_LANES-1:0]                lane_ld;
    logic [NUM_LANES-1:0][DATA_W-1:0]    lane_alu;
    logic [NUM_LANES-1:0][DATA_W-1:0]    lane_mem;
    wb_lane_t [NUM_LANES-1:0]            lane;
    logic [NUM_RD-1:0][DATA_W-1:0]       rd_data;
    logic [31:0]                         last_pc_q;
    logic [RETIRE_W-1:0]                 retired_q;

    // Gate with rstn so an asserted reset kills commits and forwarding immediately
    assign commit = rstn & bus.valid & ~bus.interlock;

    assign lane_rt   = {bus.l_rt,      bus.u_rt};
    assign lane_flag = {bus.l_rt_flag, bus.u_rt_flag};
    assign lane_ld   = {bus.l_is_load, bus.u_is_load};
    assign lane_alu  = {bus.l_alu,     bus.u_alu};
    assign lane_mem  = {bus.mem_doutb, bus.mem_douta};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane[i].data = lane_ld[i] ? lane_mem[i] : lane_alu[i];
        assign lane[i].rd   = lane_rt[i];
        assign lane[i].we   = commit & lane_flag[i] & (lane_rt[i] != '0);
    end

    regfile_2w4r #(
        .NUM_WR  (NUM_LANES),
        .NUM_RDP (NUM_RD)
    ) u_rf (
        .clk     (clk),
        .rstn    (rstn),
        .wr      (lane),
        .rd_addr (bus.rs_addr),
        .rd_data (rd_data)
    );

    assign bus.rs_data    = rd_data;
    assign bus.fwd_u_we   = lane[LANE_U].we;
    assign bus.fwd_u_rd   = lane[LANE_U].rd;
    assign bus.fwd_u_data = lane[LANE_U].data;
    assign bus.fwd_l_we   = lane[LANE_L].we;
    assign bus.fwd_l_rd   = lane[LANE_L].rd;
    assign bus.fwd_l_data = lane[LANE_L].data;

    // Retire bookkeeping: one step per non-bubble, non-held bundle; counter wraps naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_pc_q <= '0;
            retired_q <= '0;
        end else if (commit) begin
            last_pc_q <= bus.pc;
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.last_pc = last_pc_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: stimulus pushes expected outputs,
// a monitor pops and compares while each bundle is stable.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             interlock;
        logic             valid;
        logic [31:0]      pc;
        logic [4:0]       u_rt;
        logic [4:0]       l_rt;
        logic             u_f;
        logic             l_f;
        logic             u_ld;
        logic             l_ld;
        logic [31:0]      u_alu;
        logic [31:0]      l_alu;
        logic [31:0]      da;
        logic [31:0]      db;
        logic [3:0][4:0]  ra;
    } in_t;

    typedef struct {
        logic        uwe;
        logic [4:0]  urd;
        logic [31:0] udata;
        logic        lwe;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [31:0] rs [4];
        logic [31:0] lpc;
        logic [47:0] ret;
        logic [3:0]  ret_s;
        int          tag;
    } exp_t;

    in_t  drv = '0;
    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [31:0]     regs [32];
    longint unsigned commits = 0;
    logic [31:0]     lpc_m   = '0;

    writeback_regfile_if #(.RETIRE_W(48)) bus ();
    writeback_regfile_if #(.RETIRE_W(4))  bus_s ();

    assign bus.interlock   = drv.interlock;    assign bus_s.interlock = drv.interlock;
    assign bus.valid       = drv.valid;        assign bus_s.valid     = drv.valid;
    assign bus.pc          = drv.pc;           assign bus_s.pc        = drv.pc;
    assign bus.u_rt        = drv.u_rt;         assign bus_s.u_rt      = drv.u_rt;
    assign bus.l_rt        = drv.l_rt;         assign bus_s.l_rt      = drv.l_rt;
    assign bus.u_rt_flag   = drv.u_f;          assign bus_s.u_rt_flag = drv.u_f;
    assign bus.l_rt_flag   = drv.l_f;          assign bus_s.l_rt_flag = drv.l_f;
    assign bus.u_is_load   = drv.u_ld;         assign bus_s.u_is_load = drv.u_ld;
    assign bus.l_is_load   = drv.l_ld;         assign bus_s.l_is_load = drv.l_ld;
    assign bus.u_alu       = drv.u_alu;        assign bus_s.u_alu     = drv.u_alu;
    assign bus.l_alu       = drv.l_alu;        assign bus_s.l_alu     = drv.l_alu;
    assign bus.mem_douta   = drv.da;           assign bus_s.mem_douta = drv.da;
    assign bus.mem_doutb   = drv.db;           assign bus_s.mem_doutb = drv.db;
    assign bus.rs_addr     = drv.ra;           assign bus_s.rs_addr   = drv.ra;

    writeback_regfile #(.RETIRE_W(48)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // Narrow-counter copy, so wrap-around is reachable in a short run
    writeback_regfile #(.RETIRE_W(4)) dut_s (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_s.slave)
    );

    task automatic chk(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
        end
    endtask

    // Present one bundle at the falling edge, predict outputs, then advance the model past the next rising edge
    task automatic step(input in_t s, input int tag, input logic rst_v);
        exp_t        e;
        logic [31:0] nxt [32];
        logic [31:0] ures, lres;
        logic        go;
        @(negedge clk);
        rstn = rst_v;
        drv  = s;
        if (!rst_v) begin
            foreach (regs[i]) regs[i] = '0;
            commits = 0;
            lpc_m   = '0;
        end
        ures = s.u_ld ? s.da : s.u_alu;
        lres = s.l_ld ? s.db : s.l_alu;
        go   = rst_v && s.valid && !s.interlock;
        nxt  = regs;
        // Program order: upper then lower, so lower overwrites on a conflict
        if (go && s.u_f && s.u_rt != 5'd0) nxt[s.u_rt] = ures;
        if (go && s.l_f && s.l_rt != 5'd0) nxt[s.l_rt] = lres;
        e.uwe   = go && s.u_f && (s.u_rt != 5'd0);
        e.urd   = s.u_rt;
        e.udata = ures;
        e.lwe   = go && s.l_f && (s.l_rt != 5'd0);
        e.lrd   = s.l_rt;
        e.ldata = lres;
        for (int p = 0; p < 4; p++)
            e.rs[p] = (s.ra[p] == 5'd0) ? 32'd0 : nxt[s.ra[p]];
        e.lpc   = lpc_m;
        e.ret   = commits[47:0];
        e.ret_s = commits[3:0];
        e.tag   = tag;
        #1 q.push_back(e);
        regs = nxt;
        if (go) begin
            commits++;
            lpc_m = s.pc;
        end
    endtask

    // Monitor: compare the oldest prediction while the bundle is stable, away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fwd_u_we", e.tag, 64'(bus.fwd_u_we), 64'(e.uwe));
                if (e.uwe) begin
                    chk("fwd_u_rd",   e.tag, 64'(bus.fwd_u_rd),   64'(e.urd));
                    chk("fwd_u_data", e.tag, 64'(bus.fwd_u_data), 64'(e.udata));
                end
                chk("fwd_l_we", e.tag, 64'(bus.fwd_l_we), 64'(e.lwe));
                if (e.lwe) begin
                    chk("fwd_l_rd",   e.tag, 64'(bus.fwd_l_rd),   64'(e.lrd));
                    chk("fwd_l_data", e.tag, 64'(bus.fwd_l_data), 64'(e.ldata));
                end
                for (int p = 0; p < 4; p++)
                    chk($sformatf("rs_data%0d", p), e.tag, 64'(bus.rs_data[p]), 64'(e.rs[p]));
                chk("last_pc",   e.tag, 64'(bus.last_pc),   64'(e.lpc));
                chk("retired",   e.tag, 64'(bus.retired),   64'(e.ret));
                chk("retired_w", e.tag, 64'(bus_s.retired), 64'(e.ret_s));
            end
        end
    end

    initial begin
        in_t s;
        foreach (regs[i]) regs[i] = '0;

        // Reset state
        s = '0;
        step(s, 1, 1'b0);
        step(s, 1, 1'b0);

        // ALU commit, bypass read, then array read
        s = '0; s.valid = 1'b1; s.pc = 32'h100; s.u_rt = 5'd5; s.u_f = 1'b1;
        s.u_alu = 32'h1234; s.ra[0] = 5'd5;
        step(s, 2, 1'b1);
        s = '0; s.ra[0] = 5'd5;
        step(s, 2, 1'b1);

        // Load on lower lane vs ALU on upper, same destination
        s = '0; s.valid = 1'b1; s.pc = 32'h104; s.u_rt = 5'd7; s.l_rt = 5'd7;
        s.u_f = 1'b1; s.l_f = 1'b1; s.l_ld = 1'b1; s.db = 32'hDEADBEEF; s.u_alu = 32'd1;
        s.ra[2] = 5'd7;
        step(s, 3, 1'b1);
        s = '0; s.ra[2] = 5'd7; s.ra[3] = 5'd5;
        step(s, 3, 1'b1);

        // r0 write is dropped everywhere
        s = '0; s.valid = 1'b1; s.pc = 32'h108; s.l_rt = 5'd0; s.l_f = 1'b1; s.l_alu = 32'hFFFF;
        step(s, 4, 1'b1);
        step('0, 4, 1'b1);

        // Interlocked bundle held three cycles, other inputs wiggling, then one commit
        for (int k = 0; k < 3; k++) begin
            s = '0; s.valid = 1'b1; s.interlock = 1'b1; s.pc = 32'h10C; s.u_rt = 5'd3;
            s.u_f = 1'b1; s.u_alu = 32'd9; s.l_alu = $urandom; s.da = $urandom; s.ra[1] = 5'd3;
            step(s, 5, 1'b1);
        end
        s.interlock = 1'b0;
        step(s, 5, 1'b1);
        s = '0; s.ra[1] = 5'd3;
        step(s, 5, 1'b1);

        // Bubble with flags set writes nothing
        s = '0; s.valid = 1'b0; s.pc = 32'h200; s.u_rt = 5'd4; s.u_f = 1'b1; s.u_alu = 32'hABCD;
        s.l_rt = 5'd6; s.l_f = 1'b1; s.l_alu = 32'h5555; s.ra[0] = 5'd4; s.ra[1] = 5'd6;
        step(s, 6, 1'b1);
        s.valid = 1'b0;
        step(s, 6, 1'b1);

        // Reset lands on a held bundle: discarded; first edge after release commits only real bundles
        s = '0; s.valid = 1'b1; s.interlock = 1'b1; s.pc = 32'h300; s.u_rt = 5'd8; s.u_f = 1'b1;
        s.u_alu = 32'h77; s.ra[0] = 5'd8; s.ra[1] = 5'd7;
        step(s, 7, 1'b1);
        s.interlock = 1'b0;
        step(s, 7, 1'b0);
        s.valid = 1'b0;
        step(s, 7, 1'b1);
        s.valid = 1'b1;
        step(s, 7, 1'b1);

        // Randomized traffic; >16 commits wraps the narrow counter
        for (int i = 0; i < 400; i++) begin
            s           = '0;
            s.valid     = ($urandom_range(0, 3) != 0);
            s.interlock = ($urandom_range(0, 4) == 0);
            s.pc        = $urandom;
            s.u_rt      = 5'($urandom_range(0, 11));
            s.l_rt      = 5'($urandom_range(0, 11));
            s.u_f       = 1'($urandom_range(0, 1));
            s.l_f       = 1'($urandom_range(0, 1));
            s.u_ld      = 1'($urandom_range(0, 1));
            s.l_ld      = 1'($urandom_range(0, 1));
            s.u_alu     = $urandom;
            s.l_alu     = $urandom;
            s.da        = $urandom;
            s.db        = $urandom;
            for (int p = 0; p < 4; p++)
                s.ra[p] = 5'($urandom_range(0, 11));
            step(s, 100 + i, ($urandom_range(0, 59) != 0));
        end

        step('0, 999, 1'b1);
        @(negedge clk);
        #4;
        chk("drain", 999, 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
